// File: rtl/irda_mode_sequencer.sv
// IrDA PHY mode sequencer: drains TX, holds the pad idle for a guard time, pulses the
// target PHY reset, then commits the new mode. All outputs are registered.
module irda_mode_sequencer #(
  parameter int unsigned NUM_MODES  = 3,
  parameter int unsigned MODE_W     = 2,
  parameter int unsigned RESET_MODE = 0,
  parameter int unsigned GUARD_W    = 16,
  parameter int unsigned TIMEOUT_W  = 20,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 wb_rst_i,
  input  logic                 req_valid_i,
  input  logic [MODE_W-1:0]    req_mode_i,
  output logic                 req_ready_o,
  input  logic                 abort_i,
  input  logic [GUARD_W-1:0]   guard_cycles_i,
  input  logic [TIMEOUT_W-1:0] drain_timeout_i,
  input  logic [NUM_MODES-1:0] tx_busy_i,
  input  logic                 txfifo_empty_i,
  output logic                 tx_hold_o,
  output logic [MODE_W-1:0]    mode_o,
  output logic [NUM_MODES-1:0] mode_onehot_o,
  output logic [NUM_MODES-1:0] phy_rst_o,
  output logic                 switch_done_o,
  output logic                 switch_err_o,
  output logic                 busy_o
);

  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [NUM_MODES-1:0] OneLsb = {{(NUM_MODES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StDrain, StGuard, StReset, StCommit} state_e;

  state_e                 r_state;
  logic [MODE_W-1:0]      r_target;
  logic [MODE_W-1:0]      r_mode;
  logic [NUM_MODES-1:0]   r_onehot;
  logic [GUARD_W-1:0]     r_guard_cnt;
  logic [TIMEOUT_W-1:0]   r_to_cnt;
  logic                   r_to_en;
  logic [RcW-1:0]         r_rst_cnt;
  logic                   r_ready;
  logic                   r_hold;
  logic [NUM_MODES-1:0]   r_phy_rst;
  logic                   r_done;
  logic                   r_err;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_invalid;
  logic                   w_drained;
  logic [NUM_MODES-1:0]   w_target_onehot;

  assign w_accept        = req_valid_i & r_ready;
  assign w_invalid       = 32'(req_mode_i) >= NUM_MODES;
  assign w_drained       = ~tx_busy_i[r_mode] & txfifo_empty_i;
  assign w_target_onehot = OneLsb << r_target;

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= StIdle;
      r_target    <= MODE_W'(RESET_MODE);
      r_mode      <= MODE_W'(RESET_MODE);
      r_onehot    <= OneLsb << RESET_MODE;
      r_guard_cnt <= '0;
      r_to_cnt    <= '0;
      r_to_en     <= 1'b0;
      r_rst_cnt   <= '0;
      r_ready     <= 1'b1;
      r_hold      <= 1'b0;
      r_phy_rst   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (w_invalid) begin
              r_err <= 1'b1;
            end else if (req_mode_i == r_mode) begin
              r_done <= 1'b1;
            end else begin
              r_target    <= req_mode_i;
              r_guard_cnt <= guard_cycles_i;
              r_to_cnt    <= drain_timeout_i;
              r_to_en     <= |drain_timeout_i;
              r_state     <= StDrain;
              r_ready     <= 1'b0;
              r_busy      <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (abort_i) begin
            r_state <= StIdle;
            r_err   <= 1'b1;
            r_hold  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_drained) begin
            // Exit beats a coincident timeout.
            r_state <= StGuard;
            r_hold  <= 1'b1;
          end else if (r_to_en && r_to_cnt == '0) begin
            r_state <= StIdle;
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_to_cnt != '0) begin
            r_to_cnt <= r_to_cnt - 1'b1;
          end
        end
        StGuard: begin
          if (abort_i) begin
            r_state <= StIdle;
            r_err   <= 1'b1;
            r_hold  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_guard_cnt == '0) begin
            r_state   <= StReset;
            r_phy_rst <= w_target_onehot;
            r_rst_cnt <= RcW'(RST_CYCLES - 1);
          end else begin
            r_guard_cnt <= r_guard_cnt - 1'b1;
          end
        end
        StReset: begin
          if (r_rst_cnt == '0) begin
            r_state   <= StCommit;
            r_phy_rst <= '0;
            r_hold    <= 1'b0;
            r_mode    <= r_target;
            r_onehot  <= w_target_onehot;
            r_done    <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt - 1'b1;
          end
        end
        StCommit: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o   = r_ready;
  assign tx_hold_o     = r_hold;
  assign mode_o        = r_mode;
  assign mode_onehot_o = r_onehot;
  assign phy_rst_o     = r_phy_rst;
  assign switch_done_o = r_done;
  assign switch_err_o  = r_err;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_irda_mode_sequencer.sv
// Directed bench for irda_mode_sequencer; done/err pulses are matched against a queue of
// expected outcomes pushed when each request is issued.
module tb_irda_mode_sequencer;

  logic        clk;
  logic        wb_rst_i;
  logic        req_valid_i;
  logic [1:0]  req_mode_i;
  logic        req_ready_o;
  logic        abort_i;
  logic [15:0] guard_cycles_i;
  logic [19:0] drain_timeout_i;
  logic [2:0]  tx_busy_i;
  logic        txfifo_empty_i;
  logic        tx_hold_o;
  logic [1:0]  mode_o;
  logic [2:0]  mode_onehot_o;
  logic [2:0]  phy_rst_o;
  logic        switch_done_o;
  logic        switch_err_o;
  logic        busy_o;

  typedef struct {
    logic       done;
    logic       err;
    logic [1:0] mode;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  irda_mode_sequencer dut (
    .clk             (clk),
    .wb_rst_i        (wb_rst_i),
    .req_valid_i     (req_valid_i),
    .req_mode_i      (req_mode_i),
    .req_ready_o     (req_ready_o),
    .abort_i         (abort_i),
    .guard_cycles_i  (guard_cycles_i),
    .drain_timeout_i (drain_timeout_i),
    .tx_busy_i       (tx_busy_i),
    .txfifo_empty_i  (txfifo_empty_i),
    .tx_hold_o       (tx_hold_o),
    .mode_o          (mode_o),
    .mode_onehot_o   (mode_onehot_o),
    .phy_rst_o       (phy_rst_o),
    .switch_done_o   (switch_done_o),
    .switch_err_o    (switch_err_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic d, input logic e, input logic [1:0] m);
    exp_t x;
    x.done = d;
    x.err  = e;
    x.mode = m;
    sb.push_back(x);
  endtask

  // Request accepted at the next rising edge; returns just after that edge.
  task automatic do_req(input logic [1:0] m, input logic [15:0] g, input logic [19:0] t);
    @(negedge clk);
    req_valid_i     = 1'b1;
    req_mode_i      = m;
    guard_cycles_i  = g;
    drain_timeout_i = t;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (wb_rst_i && (switch_done_o || switch_err_o)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pulse", 32'({switch_done_o, switch_err_o}), 32'(0));
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("sb_done", 32'(switch_done_o), 32'(x.done));
        check("sb_err", 32'(switch_err_o), 32'(x.err));
        check("sb_mode", 32'(mode_o), 32'(x.mode));
      end
    end
  end

  initial begin
    int  err_pulses;
    bit  hold_seen;
    bit  finished;
    wb_rst_i        = 1'b0;
    req_valid_i     = 1'b0;
    req_mode_i      = 2'd0;
    abort_i         = 1'b0;
    guard_cycles_i  = '0;
    drain_timeout_i = '0;
    tx_busy_i       = 3'b000;
    txfifo_empty_i  = 1'b1;
    #12;
    check("rst_mode", 32'(mode_o), 32'(0));
    check("rst_onehot", 32'(mode_onehot_o), 32'(3'b001));
    check("rst_ready", 32'(req_ready_o), 32'(1));
    check("rst_hold", 32'(tx_hold_o), 32'(0));
    check("rst_phy_rst", 32'(phy_rst_o), 32'(0));
    check("rst_busy", 32'({switch_done_o, switch_err_o, busy_o}), 32'(0));
    @(negedge clk);
    wb_rst_i = 1'b1;

    // Full switch 0 -> 2, G=3, cycle-accurate.
    push_exp(1'b1, 1'b0, 2'd2);
    do_req(2'd2, 16'd3, 20'd0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("sw_hold_c%0d", c), 32'(tx_hold_o), 32'(c >= 2 && c <= 9));
      check($sformatf("sw_phyrst_c%0d", c), 32'(phy_rst_o),
            (c >= 6 && c <= 9) ? 32'(3'b100) : 32'(0));
      check($sformatf("sw_done_c%0d", c), 32'(switch_done_o), 32'(c == 10));
      check($sformatf("sw_mode_c%0d", c), 32'(mode_o), (c == 10) ? 32'(2) : 32'(0));
      if (c == 1) check("sw_ready_c1", 32'(req_ready_o), 32'(0));
    end
    check("sw_onehot", 32'(mode_onehot_o), 32'(3'b100));
    @(negedge clk);
    check("sw_ready_after", 32'(req_ready_o), 32'(1));

    // Drain timeout: active transmitter stays busy, T=5.
    tx_busy_i = 3'b100;
    push_exp(1'b0, 1'b1, 2'd2);
    do_req(2'd0, 16'd0, 20'd5);
    err_pulses = 0;
    hold_seen  = 1'b0;
    finished   = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      if (tx_hold_o) hold_seen = 1'b1;
      if (switch_err_o) err_pulses++;
      if (!busy_o) finished = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      if (switch_err_o) err_pulses++;
    end
    check("to_finished", 32'(finished), 32'(1));
    check("to_err_once", 32'(err_pulses), 32'(1));
    check("to_hold_never", 32'(hold_seen), 32'(0));
    check("to_mode", 32'(mode_o), 32'(2));
    tx_busy_i = 3'b000;

    // Invalid mode index.
    push_exp(1'b0, 1'b1, 2'd2);
    do_req(2'd3, 16'd0, 20'd0);
    @(negedge clk);
    check("inv_err_c1", 32'(switch_err_o), 32'(1));
    check("inv_busy_c1", 32'(busy_o), 32'(0));
    @(negedge clk);
    check("inv_err_c2", 32'(switch_err_o), 32'(0));
    check("inv_ready_c2", 32'(req_ready_o), 32'(1));

    // No-op request to the current mode.
    push_exp(1'b1, 1'b0, 2'd2);
    do_req(2'd2, 16'd2, 20'd0);
    @(negedge clk);
    check("noop_done_c1", 32'(switch_done_o), 32'(1));
    check("noop_quiet_c1", 32'({tx_hold_o, phy_rst_o}), 32'(0));
    @(negedge clk);
    check("noop_quiet_c2", 32'({switch_done_o, tx_hold_o, phy_rst_o, busy_o}), 32'(0));

    // Abort during GUARD.
    push_exp(1'b0, 1'b1, 2'd2);
    do_req(2'd1, 16'd10, 20'd0);
    @(negedge clk);
    @(negedge clk);
    check("ab_guard_hold", 32'(tx_hold_o), 32'(1));
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("ab_err", 32'(switch_err_o), 32'(1));
    check("ab_hold_drop", 32'(tx_hold_o), 32'(0));
    check("ab_idle", 32'({busy_o, req_ready_o}), 32'(2'b01));
    check("ab_mode", 32'(mode_o), 32'(2));

    // Abort during RESET is ignored; G=0 gives a single guard cycle.
    push_exp(1'b1, 1'b0, 2'd1);
    do_req(2'd1, 16'd0, 20'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ar_phyrst_c3", 32'(phy_rst_o), 32'(3'b010));
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("ar_phyrst_c4", 32'(phy_rst_o), 32'(3'b010));
    check("ar_hold_c4", 32'(tx_hold_o), 32'(1));
    check("ar_noerr_c4", 32'(switch_err_o), 32'(0));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ar_done_c7", 32'(switch_done_o), 32'(1));
    check("ar_mode_c7", 32'(mode_o), 32'(1));
    check("ar_onehot_c7", 32'(mode_onehot_o), 32'(3'b010));

    // Drain waits on a non-empty FIFO with T=0 (no timeout).
    @(negedge clk);
    txfifo_empty_i = 1'b0;
    push_exp(1'b1, 1'b0, 2'd0);
    do_req(2'd0, 16'd1, 20'd0);
    hold_seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (tx_hold_o) hold_seen = 1'b1;
    end
    check("dw_hold_blocked", 32'(hold_seen), 32'(0));
    check("dw_still_busy", 32'(busy_o), 32'(1));
    txfifo_empty_i = 1'b1;
    finished = 1'b0;
    for (int c = 0; c < 30 && !finished; c++) begin
      @(negedge clk);
      if (switch_done_o) finished = 1'b1;
    end
    check("dw_completed", 32'(finished), 32'(1));
    check("dw_mode", 32'(mode_o), 32'(0));

    // Async reset in the middle of RESET.
    @(negedge clk);
    push_exp(1'b1, 1'b0, 2'd2);
    do_req(2'd2, 16'd0, 20'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ar2_phyrst", 32'(phy_rst_o), 32'(3'b100));
    #1;
    wb_rst_i = 1'b0;
    #1;
    sb.delete();
    check("ar2_phyrst_clr", 32'(phy_rst_o), 32'(0));
    check("ar2_mode", 32'(mode_o), 32'(0));
    check("ar2_onehot", 32'(mode_onehot_o), 32'(3'b001));
    check("ar2_idle", 32'({tx_hold_o, busy_o, req_ready_o}), 32'(3'b001));
    @(negedge clk);
    wb_rst_i = 1'b1;
    push_exp(1'b1, 1'b0, 2'd1);
    do_req(2'd1, 16'd1, 20'd0);
    finished = 1'b0;
    for (int c = 0; c < 30 && !finished; c++) begin
      @(negedge clk);
      if (switch_done_o) finished = 1'b1;
    end
    check("post_rst_done", 32'(finished), 32'(1));
    check("post_rst_mode", 32'(mode_o), 32'(1));

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
